inst_fetch_responder: RTL and testbench

- Memory-side responder for the instruction-fetch request port driven by the IF stage.
- Accepts a 32-bit fetch request (inst_re, inst_raddr), performs four byte reads on the byte-wide RAM port, and returns the little-endian instruction word on inst_rdata.
- inst_busy brackets every transaction so the IF stage can stall and sample on its falling edge.
- A one-entry last-word buffer answers a repeated fetch of the same address without touching RAM.

---
 rtl/inst_fetch_responder.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: turns a 32-bit fetch into four byte reads on a
// 1-cycle-latency RAM port, with a one-entry last-word buffer for repeat fetches.
module inst_fetch_responder #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              inst_re,
    input  logic [31:0]       inst_raddr,
    input  logic              flush_buf,
    output logic [31:0]       inst_rdata,
    output logic              inst_busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [7:0]        mem_din
);
    typedef enum logic [1:0] {IDLE, ISSUE, LAST, HIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_k, w_k_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
    logic [ADDR_W-1:0] r_buf_addr, w_buf_addr_nxt;
    logic [23:0]       r_bytes, w_bytes_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic [31:0]       r_buf_word, w_buf_word_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_buf_valid, w_buf_valid_nxt;
    logic              r_restart, w_restart_nxt;
    logic [ADDR_W-1:0] w_req_base;
    logic              w_hit;
    logic              w_unused;

    assign w_req_base = inst_raddr[ADDR_W-1:0];
    assign w_unused   = ^inst_raddr;
    assign w_hit      = r_buf_valid && (r_buf_addr == w_req_base) && !flush_buf;

    assign inst_rdata = r_rdata;
    assign inst_busy  = r_busy;
    assign mem_a      = r_mem_a;
    // A pending restart suppresses the read until the address is re-seeded at base.
    assign mem_rd     = (r_state == ISSUE) && rdy && !r_restart;

    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_base_nxt      = r_base;
        w_mem_a_nxt     = r_mem_a;
        w_buf_addr_nxt  = r_buf_addr;
        w_bytes_nxt     = r_bytes;
        w_rdata_nxt     = r_rdata;
        w_buf_word_nxt  = r_buf_word;
        w_busy_nxt      = r_busy;
        w_buf_valid_nxt = r_buf_valid;
        w_restart_nxt   = r_restart;
        if (rdy) begin
            if (r_restart) begin
                w_state_nxt   = ISSUE;
                w_k_nxt       = 2'd0;
                w_mem_a_nxt   = r_base;
                w_restart_nxt = 1'b0;
            end else begin
                case (r_state)
                    ISSUE: begin
                        case (r_k)
                            2'd1:    w_bytes_nxt[7:0]   = mem_din;
                            2'd2:    w_bytes_nxt[15:8]  = mem_din;
                            2'd3:    w_bytes_nxt[23:16] = mem_din;
                            default: ;
                        endcase
                        if (r_k == 2'd3) begin
                            w_state_nxt = LAST;
                        end else begin
                            w_k_nxt     = r_k + 2'd1;
                            w_mem_a_nxt = r_base + ADDR_W'({1'b0, r_k} + 3'd1);
                        end
                    end
                    LAST: begin
                        w_rdata_nxt     = {mem_din, r_bytes};
                        w_buf_word_nxt  = {mem_din, r_bytes};
                        w_buf_addr_nxt  = r_base;
                        w_buf_valid_nxt = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                    HIT: begin
                        w_rdata_nxt = r_buf_word;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
            // A new request overrides any progress above; a completion on the
            // same edge still delivers its word.
            if (inst_re) begin
                w_base_nxt    = w_req_base;
                w_busy_nxt    = 1'b1;
                w_restart_nxt = 1'b0;
                if (w_hit) begin
                    w_state_nxt = HIT;
                end else begin
                    w_state_nxt = ISSUE;
                    w_k_nxt     = 2'd0;
                    w_mem_a_nxt = w_req_base;
                end
            end
        end else if (r_state == ISSUE || r_state == LAST) begin
            w_restart_nxt = 1'b1;
        end
        if (flush_buf) w_buf_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_k         <= 2'd0;
            r_base      <= '0;
            r_mem_a     <= '0;
            r_buf_addr  <= '0;
            r_bytes     <= '0;
            r_rdata     <= '0;
            r_buf_word  <= '0;
            r_busy      <= 1'b0;
            r_buf_valid <= 1'b0;
            r_restart   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_base      <= w_base_nxt;
            r_mem_a     <= w_mem_a_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_bytes     <= w_bytes_nxt;
            r_rdata     <= w_rdata_nxt;
            r_buf_word  <= w_buf_word_nxt;
            r_busy      <= w_busy_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_restart   <= w_restart_nxt;
        end
    end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: a 32-bit and a 17-bit instance share
// stimulus; a transaction-level model is checked every cycle plus literal checks.
module tb_inst_fetch_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        inst_re = 1'b0;
    logic [31:0] inst_raddr = '0;
    logic        flush_buf = 1'b0;

    logic [31:0] rdata32, rdata17;
    logic        busy32, busy17, memrd32, memrd17;
    logic [31:0] mema32;
    logic [16:0] mema17;
    logic [7:0]  din32 = '0, din17 = '0;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0] ram [int unsigned];

    always #5 clk = ~clk;

    inst_fetch_responder #(.ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .rdy(rdy), .inst_re(inst_re), .inst_raddr(inst_raddr),
        .flush_buf(flush_buf), .inst_rdata(rdata32), .inst_busy(busy32),
        .mem_rd(memrd32), .mem_a(mema32), .mem_din(din32));

    inst_fetch_responder #(.ADDR_W(17)) u_dut17 (
        .clk(clk), .rst(rst), .rdy(rdy), .inst_re(inst_re), .inst_raddr(inst_raddr),
        .flush_buf(flush_buf), .inst_rdata(rdata17), .inst_busy(busy17),
        .mem_rd(memrd17), .mem_a(mema17), .mem_din(din17));

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Byte-wide RAM with one cycle of read latency.
    always @(posedge clk) begin
        din32 <= rd(mema32);
        din17 <= rd({15'd0, mema17});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] MASK [2];
    logic [31:0] m_base [2], m_rdata [2], m_ba [2], m_bw [2];
    bit          m_busy [2], m_hit [2], m_rp [2], m_bv [2];
    int          m_ph [2];

    initial begin
        MASK[0] = 32'hFFFF_FFFF;
        MASK[1] = 32'h0001_FFFF;
    end

    function automatic logic [31:0] word_at(input logic [31:0] b, input logic [31:0] m);
        return {rd((b + 32'd3) & m), rd((b + 32'd2) & m), rd((b + 32'd1) & m), rd(b & m)};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i] = '0; m_rdata[i] = '0; m_ba[i] = '0; m_bw[i] = '0;
            m_busy[i] = 0; m_hit[i] = 0; m_rp[i] = 0; m_bv[i] = 0; m_ph[i] = 0;
        end
    endtask

    // Applies the inputs that the next rising edge will sample.
    task automatic m_advance();
        bit done, ob_v;
        logic [31:0] ob_a, b;
        for (int i = 0; i < 2; i++) begin
            ob_v = m_bv[i];
            ob_a = m_ba[i];
            if (!rdy) begin
                if (m_busy[i] && !m_hit[i]) m_rp[i] = 1;
            end else begin
                done = m_busy[i] && !m_rp[i] && (m_hit[i] || m_ph[i] == 4);
                if (done) begin
                    if (m_hit[i]) m_rdata[i] = m_bw[i];
                    else begin
                        m_rdata[i] = word_at(m_base[i], MASK[i]);
                        m_bv[i] = 1; m_ba[i] = m_base[i]; m_bw[i] = m_rdata[i];
                    end
                    m_busy[i] = 0;
                end else if (m_busy[i]) begin
                    if (m_rp[i]) begin m_rp[i] = 0; m_ph[i] = 0; end
                    else if (!m_hit[i]) m_ph[i]++;
                end
                if (inst_re) begin
                    b = inst_raddr & MASK[i];
                    m_base[i] = b; m_busy[i] = 1; m_rp[i] = 0; m_ph[i] = 0;
                    m_hit[i] = ob_v && (ob_a == b) && !flush_buf;
                end
            end
            if (flush_buf) m_bv[i] = 0;
        end
    endtask

    logic [31:0] d_rdata [2], d_mema [2];
    logic        d_busy [2], d_memrd [2];
    assign d_rdata[0] = rdata32; assign d_rdata[1] = rdata17;
    assign d_busy[0]  = busy32;  assign d_busy[1]  = busy17;
    assign d_memrd[0] = memrd32; assign d_memrd[1] = memrd17;
    assign d_mema[0]  = mema32;  assign d_mema[1]  = {15'd0, mema17};

    // Single compare process: inputs change just after posedge, so at negedge
    // they equal what the next posedge samples.
    initial begin
        bit exp_rd;
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst) m_reset();
            for (int i = 0; i < 2; i++) begin
                exp_rd = m_busy[i] && !m_hit[i] && !m_rp[i] && (m_ph[i] < 4) && rdy;
                chk(i == 0 ? "busy32" : "busy17", {31'd0, d_busy[i]}, {31'd0, m_busy[i]});
                chk(i == 0 ? "rdata32" : "rdata17", d_rdata[i], m_rdata[i]);
                chk(i == 0 ? "memrd32" : "memrd17", {31'd0, d_memrd[i]}, {31'd0, exp_rd});
                if (exp_rd)
                    chk(i == 0 ? "mema32" : "mema17", d_mema[i], (m_base[i] + m_ph[i]) & MASK[i]);
            end
            if (rst) m_advance();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input bit fl);
        inst_re = 1'b1; inst_raddr = a; flush_buf = fl;
        tick();
        inst_re = 1'b0; flush_buf = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, output bit saw_rd);
        cyc = 0; saw_rd = 0;
        while (busy32 && cyc < 50) begin
            if (memrd32 || memrd17) saw_rd = 1;
            cyc++;
            tick();
        end
        if (cyc >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL wait_idle: busy still high after %0d cycles", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit saw;
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h200] = 8'h6F; ram[32'h201] = 8'h00; ram[32'h202] = 8'h00; ram[32'h203] = 8'h00;
        ram[32'h40] = 8'hEF; ram[32'h41] = 8'hBE; ram[32'h42] = 8'hAD; ram[32'h43] = 8'hDE;
        ram[32'h1FFFE] = 8'hAA; ram[32'h1FFFF] = 8'hBB;

        #1 rst = 1'b0;
        repeat (3) tick();
        chk("reset_busy", {31'd0, busy32}, 32'd0);
        chk("reset_rdata", rdata32, 32'd0);
        chk("reset_memrd", {31'd0, memrd32}, 32'd0);
        chk("reset_mema", mema32, 32'd0);
        rst = 1'b1;
        tick();

        // Miss at 0x0
        req(32'h0, 0);
        wait_idle(cyc, saw);
        chk("miss0_cycles", cyc, 5);
        chk("miss0_rdata32", rdata32, 32'h0000_0513);
        chk("miss0_rdata17", rdata17, 32'h0000_0513);
        tick();

        // Repeat -> buffer hit, no RAM access
        req(32'h0, 0);
        wait_idle(cyc, saw);
        chk("hit0_cycles", cyc, 1);
        chk("hit0_no_memrd", {31'd0, saw}, 32'd0);
        chk("hit0_rdata", rdata32, 32'h0000_0513);

        // Same request with flush on the request edge -> full fetch
        req(32'h0, 1);
        wait_idle(cyc, saw);
        chk("flush_miss_cycles", cyc, 5);
        tick();

        // Redirect during third ISSUE cycle
        req(32'h100, 0);
        tick();
        tick();
        req(32'h200, 0);
        wait_idle(cyc, saw);
        chk("redirect_cycles", cyc, 5);
        chk("redirect_rdata", rdata32, 32'h0000_006F);
        req(32'h200, 0);
        wait_idle(cyc, saw);
        chk("redirect_hit_cycles", cyc, 1);

        // rdy low mid-fetch; a request while paused is ignored
        req(32'h40, 0);
        tick();
        rdy = 1'b0; inst_re = 1'b1; inst_raddr = 32'h100;
        repeat (3) tick();
        chk("paused_memrd", {31'd0, memrd32}, 32'd0);
        inst_re = 1'b0; rdy = 1'b1;
        wait_idle(cyc, saw);
        chk("pause_cycles", cyc, 6);
        chk("pause_rdata32", rdata32, 32'hDEAD_BEEF);
        chk("pause_rdata17", rdata17, 32'hDEAD_BEEF);
        tick();

        // Reset mid-fetch of a buffered address -> miss afterwards
        req(32'h40, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy32}, 32'd0);
        chk("midrst_rdata", rdata32, 32'd0);
        chk("midrst_memrd", {31'd0, memrd32}, 32'd0);
        chk("midrst_mema", mema32, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        req(32'h40, 0);
        wait_idle(cyc, saw);
        chk("postrst_cycles", cyc, 5);
        chk("postrst_rdata", rdata32, 32'hDEAD_BEEF);

        // Address wrap in the 17-bit instance
        ram[0] = 8'hCC; ram[1] = 8'hDD;
        req(32'h1FFFE, 0);
        tick();
        tick();
        chk("wrap_mema17", {15'd0, mema17}, 32'd0);
        chk("wrap_memrd17", {31'd0, memrd17}, 32'd1);
        wait_idle(cyc, saw);
        chk("wrap_rdata17", rdata17, 32'hDDCC_BBAA);
        chk("wrap_rdata32", rdata32, 32'h0000_BBAA);

        // Flush during HIT still delivers, then next fetch misses
        req(32'h1FFFE, 0);
        flush_buf = 1'b1;
        tick();
        flush_buf = 1'b0;
        chk("flushhit_busy", {31'd0, busy17}, 32'd0);
        chk("flushhit_rdata17", rdata17, 32'hDDCC_BBAA);
        req(32'h1FFFE, 0);
        wait_idle(cyc, saw);
        chk("flushhit_miss_cycles", cyc, 5);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
